// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited memory requests, in-order response FIFO,
// valid/ready delivery to decode, and redirect flush with stale-response dropping.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  output logic            mem_req_valid_out,
  input  logic            mem_req_ready_in,
  output logic [XLEN-1:0] mem_req_addr_out,
  input  logic            mem_rsp_valid_in,
  input  logic [31:0]     mem_rsp_data_in,
  output logic            instr_valid_out,
  input  logic            instr_ready_in,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  input  logic            redirect_valid_in,
  input  logic [XLEN-1:0] redirect_pc_in
);

  localparam int              PW         = $clog2(DEPTH);
  localparam int              CW         = PW + 1;
  localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1'b1);
  localparam logic [PW-1:0]   PTR_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1'b1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'b11));

  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] push_pc_q, push_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     data_q [DEPTH];
  logic [XLEN-1:0] pcs_q  [DEPTH];

  logic [CW:0]     inflight_s;
  logic            req_fire_s, rsp_s, push_s, pop_s;
  logic [CW-1:0]   req_inc_s, rsp_dec_s, push_inc_s, pop_dec_s;
  logic [XLEN-1:0] target_s;

  // Handshake qualifiers and outputs; run_q holds requests off until the cycle after reset.
  always_comb begin
    inflight_s        = {1'b0, count_q} + {1'b0, out_q};
    mem_req_valid_out = run_q && (inflight_s < DEPTH_W) && !redirect_valid_in;
    mem_req_addr_out  = fetch_pc_q;
    instr_valid_out   = (count_q != CNT_ZERO) && !redirect_valid_in;
    instr_out         = data_q[rd_ptr_q];
    pc_out            = pcs_q[rd_ptr_q];
    req_fire_s        = mem_req_valid_out && mem_req_ready_in;
    rsp_s             = mem_rsp_valid_in && (out_q != CNT_ZERO);
    push_s            = rsp_s && (drop_q == CNT_ZERO) && !redirect_valid_in;
    pop_s             = instr_valid_out && instr_ready_in;
    req_inc_s         = req_fire_s ? CNT_ONE : CNT_ZERO;
    rsp_dec_s         = rsp_s ? CNT_ONE : CNT_ZERO;
    push_inc_s        = push_s ? CNT_ONE : CNT_ZERO;
    pop_dec_s         = pop_s ? CNT_ONE : CNT_ZERO;
    target_s          = redirect_pc_in & ALIGN_MASK;
  end

  // Next-state: a redirect wins over requests, pushes and pops in the same cycle.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    push_pc_d  = push_pc_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect_valid_in) begin
      fetch_pc_d = target_s;
      push_pc_d  = target_s;
      count_d    = CNT_ZERO;
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
      out_d      = out_q - rsp_dec_s;
      drop_d     = out_q - rsp_dec_s;
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      out_d = out_q + req_inc_s - rsp_dec_s;
      if (rsp_s && (drop_q != CNT_ZERO)) begin
        drop_d = drop_q - CNT_ONE;
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
        push_pc_d = push_pc_q + PC_STEP;
      end else begin
        wr_ptr_d  = wr_ptr_q;
        push_pc_d = push_pc_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + push_inc_s - pop_dec_s;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      push_pc_q  <= RESET_PC;
      count_q    <= CNT_ZERO;
      out_q      <= CNT_ZERO;
      drop_q     <= CNT_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      push_pc_q  <= push_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; reset so the empty head reads as instr 0 at RESET_PC.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 32'h0000_0000;
        pcs_q[i]  <= RESET_PC;
      end
    end else if (push_s) begin
      data_q[wr_ptr_q] <= mem_rsp_data_in;
      pcs_q[wr_ptr_q]  <= push_pc_q;
    end else begin
      data_q[wr_ptr_q] <= data_q[wr_ptr_q];
      pcs_q[wr_ptr_q]  <= pcs_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model feeds the DUT,
// expected (instr, pc) pairs are queued by the stimulus and compared by a monitor on each pop.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_in;
  logic        rst_n_in;
  logic        mem_req_valid_out;
  logic        mem_req_ready_in;
  logic [31:0] mem_req_addr_out;
  logic        mem_rsp_valid_in;
  logic [31:0] mem_rsp_data_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(4)) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .mem_req_valid_out (mem_req_valid_out),
    .mem_req_ready_in  (mem_req_ready_in),
    .mem_req_addr_out  (mem_req_addr_out),
    .mem_rsp_valid_in  (mem_rsp_valid_in),
    .mem_rsp_data_in   (mem_rsp_data_in),
    .instr_valid_out   (instr_valid_out),
    .instr_ready_in    (instr_ready_in),
    .instr_out         (instr_out),
    .pc_out            (pc_out),
    .redirect_valid_in (redirect_valid_in),
    .redirect_pc_in    (redirect_pc_in)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;

  mreq_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          quota = 0;
  int          lat = 1;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.instr = mdata(pc);
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    repeat (3) @(negedge clk_in);
    check(nm, 32'(exp_q.size() + pend.size()), 32'd0);
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // Memory model: in-order responses 'lat' cycles after acceptance, ready while quota remains.
  initial begin
    mem_req_ready_in = 1'b0;
    mem_rsp_valid_in = 1'b0;
    mem_rsp_data_in  = 32'h0;
    forever begin
      @(posedge clk_in);
      #1;
      mem_req_ready_in = (quota > 0);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rsp_valid_in = 1'b1;
        mem_rsp_data_in  = mdata(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        mem_rsp_valid_in = 1'b0;
        mem_rsp_data_in  = 32'h0;
      end
    end
  end

  // Monitor: records accepted requests and scores every delivered instruction.
  initial forever begin
    @(negedge clk_in);
    if (rst_n_in) begin
      if (mem_req_valid_out && mem_req_ready_in) begin
        pend.push_back('{addr: mem_req_addr_out, due: cyc + lat});
        req_log.push_back(mem_req_addr_out);
        if (quota > 0) quota--;
      end
      if (instr_valid_out && instr_ready_in) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL sb_unexpected: got pc %h instr %h required no delivery", pc_out, instr_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_instr", instr_out, e.instr);
          check("sb_pc", pc_out, e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in          = 1'b0;
    instr_ready_in    = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_pc_in    = 32'h0;

    // Reset values.
    step(); step();
    @(negedge clk_in);
    check("rst_req_valid", {31'd0, mem_req_valid_out}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid_out}, 32'd0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc", pc_out, RESET_PC);

    // Streaming with 1-cycle memory and decode always ready.
    step();
    rst_n_in = 1'b1;
    instr_ready_in = 1'b1;
    lat = 1;
    quota = 8;
    req_log.delete();
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
    @(negedge clk_in);
    check("t1_no_req_release_cycle", {31'd0, mem_req_valid_out}, 32'd0);
    @(negedge clk_in);
    check("t1_first_req_valid", {31'd0, mem_req_valid_out}, 32'd1);
    check("t1_first_req_addr", mem_req_addr_out, 32'h0);
    wait_idle("t1_drain", 60);
    check("t1_nreq", 32'(req_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < req_log.size(); i++) check("t1_req_addr", req_log[i], 32'(i * 4));
    check("t1_no_gaps", (pop_cyc.size() == 8) ? 32'(pop_cyc[7] - pop_cyc[0]) : 32'hFFFF_FFFF, 32'd7);

    // Decode stalled: credit limits to DEPTH requests; then release.
    step();
    instr_ready_in = 1'b0;
    quota = 8;
    req_log.delete();
    repeat (10) step();
    @(negedge clk_in);
    check("t2_nreq_stalled", 32'(req_log.size()), 32'd4);
    check("t2_req_blocked", {31'd0, mem_req_valid_out}, 32'd0);
    check("t2_instr_valid", {31'd0, instr_valid_out}, 32'd1);
    check("t2_head_instr", instr_out, mdata(32'h20));
    check("t2_head_pc", pc_out, 32'h20);
    for (int i = 0; i < 8; i++) expect_pc(32'h20 + 32'(i * 4));
    pop_cyc.delete();
    step();
    instr_ready_in = 1'b1;
    wait_idle("t2_drain", 60);
    check("t2_back_to_back", (pop_cyc.size() >= 4) ? 32'(pop_cyc[3] - pop_cyc[0]) : 32'hFFFF_FFFF, 32'd3);
    check("t2_nreq_total", 32'(req_log.size()), 32'd8);

    // Redirect with two requests in flight at latency 3.
    step();
    lat = 3;
    quota = 2;
    step(); step(); step();
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h100;
    quota = 1;
    @(negedge clk_in);
    check("t3_req_blocked_redirect", {31'd0, mem_req_valid_out}, 32'd0);
    step();
    redirect_valid_in = 1'b0;
    expect_pc(32'h100);
    @(negedge clk_in);
    check("t3_req_valid", {31'd0, mem_req_valid_out}, 32'd1);
    check("t3_req_addr", mem_req_addr_out, 32'h100);
    check("t3_fifo_empty", {31'd0, instr_valid_out}, 32'd0);
    wait_idle("t3_drain", 40);

    // Redirect coincident with a response while decode is ready; unaligned target.
    step();
    instr_ready_in = 1'b0;
    lat = 2;
    quota = 3;
    step(); step(); step(); step();
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h203;
    instr_ready_in = 1'b1;
    quota = 1;
    @(negedge clk_in);
    check("t4_rsp_seen", {31'd0, mem_rsp_valid_in}, 32'd1);
    check("t4_no_valid_redirect", {31'd0, instr_valid_out}, 32'd0);
    step();
    redirect_valid_in = 1'b0;
    expect_pc(32'h200);
    @(negedge clk_in);
    check("t4_req_addr_aligned", mem_req_addr_out, 32'h200);
    check("t4_req_valid", {31'd0, mem_req_valid_out}, 32'd1);
    check("t4_fifo_empty", {31'd0, instr_valid_out}, 32'd0);
    wait_idle("t4_drain", 40);

    // Reset mid-stream with three buffered entries, then a spurious response.
    step();
    instr_ready_in = 1'b0;
    lat = 1;
    quota = 3;
    repeat (5) step();
    @(negedge clk_in);
    check("t6_pre_valid", {31'd0, instr_valid_out}, 32'd1);
    check("t6_pre_pc", pc_out, 32'h204);
    check("t6_pre_instr", instr_out, mdata(32'h204));
    #2;
    rst_n_in = 1'b0;
    pend.delete();
    #1;
    check("t6_async_req_valid", {31'd0, mem_req_valid_out}, 32'd0);
    check("t6_async_instr_valid", {31'd0, instr_valid_out}, 32'd0);
    check("t6_async_instr", instr_out, 32'h0);
    check("t6_async_pc", pc_out, RESET_PC);
    step();
    rst_n_in = 1'b1;
    pend.delete();
    pend.push_back('{addr: 32'hBAD0, due: cyc + 1});
    step();
    @(negedge clk_in);
    check("t6_spurious_seen", {31'd0, mem_rsp_valid_in}, 32'd1);
    check("t6_restart_valid", {31'd0, mem_req_valid_out}, 32'd1);
    check("t6_restart_addr", mem_req_addr_out, RESET_PC);
    step();
    @(negedge clk_in);
    check("t6_spurious_ignored", {31'd0, instr_valid_out}, 32'd0);
    step();
    quota = 2;
    instr_ready_in = 1'b1;
    expect_pc(RESET_PC);
    expect_pc(RESET_PC + 32'd4);
    wait_idle("t6_drain", 40);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that produces the instruction stream consumed by control_unit.
- Issues word fetches to the instruction memory port and tracks multiple outstanding requests.
- Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- On a redirect (branch/jump/trap) it flushes the FIFO and discards stale in-flight responses.

Parameters:
- XLEN, 32, PC/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, FIFO entries; also the limit on (buffered + outstanding) fetches. Power of two, ≥2.

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  asynchronous active-low reset.
- mem_req_valid_out  output  1  fetch request valid.
- mem_req_ready_in  input  1  memory accepts request.
- mem_req_addr_out  output  XLEN  word-aligned fetch address.
- mem_rsp_valid_in  input  1  response data valid; responses are in order, one per cycle max, no backpressure.
- mem_rsp_data_in  input  32  fetched instruction word.
- instr_valid_out  output  1  instruction available to decode.
- instr_ready_in  input  1  decode consumes the instruction.
- instr_out  output  32  instruction word (FIFO head).
- pc_out  output  XLEN  PC of instr_out.
- redirect_valid_in  input  1  flush and restart fetch.
- redirect_pc_in  input  XLEN  new fetch PC; bits [1:0] are ignored (forced to 0).

Behaviour:
- Clock and reset: single clock, clk_in. Reset is asynchronous and active-low on rst_n_in.
- Reset values:
  - fetch_pc = RESET_PC and push_pc = RESET_PC.
  - count = 0, outstanding = 0, drop = 0, FIFO pointers = 0.
  - Outputs: mem_req_valid_out = 0, instr_valid_out = 0, instr_out = 0, pc_out = RESET_PC.
- State (registers):
  - fetch_pc: next request address.
  - push_pc: PC of the next non-dropped response.
  - count: FIFO occupancy, 0..DEPTH.
  - outstanding: accepted requests not yet answered, 0..DEPTH.
  - drop: responses still to be discarded, ≤ outstanding.
- Request:
  - mem_req_valid_out = (count + outstanding < DEPTH) && !redirect_valid_in.
  - mem_req_addr_out = fetch_pc.
  - Request handshake (valid && ready): fetch_pc += 4 and outstanding += 1.
  - Valid may drop without handshake only when the credit or redirect condition changes.
- Response:
  - Every mem_rsp_valid_in decrements outstanding.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise: push {data, push_pc} into the FIFO and push_pc += 4.
  - Credit gating guarantees the FIFO never overflows.
  - A response with outstanding == 0 is a protocol error: ignore it (no counter underflow).
- Decode side:
  - instr_valid_out = (count != 0) && !redirect_valid_in.
  - instr_out and pc_out come from the FIFO head and are stable while valid && !ready.
  - Pop on instr_valid_out && instr_ready_in.
  - Simultaneous push and pop leave count unchanged; pointers wrap modulo DEPTH.
- Redirect (takes priority over everything in that cycle):
  - fetch_pc = push_pc = {redirect_pc_in[XLEN-1:2], 2'b00}.
  - FIFO cleared (count = 0); no pop occurs.
  - No request is issued.
  - drop = outstanding − mem_rsp_valid_in (the response arriving this cycle is discarded).
  - outstanding = outstanding − mem_rsp_valid_in.
  - Fetching resumes the next cycle. Back-to-back redirects: the last one wins.
- Latency:
  - First request is visible in the cycle after reset deasserts.
  - A response received in cycle N is visible on instr_valid_out in cycle N+1.
  - Redirect to new PC request: 1 cycle.
- Steady-state throughput: 1 instr/cycle when memory has ≥1 response/cycle and DEPTH ≥ round-trip latency + 1.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight responses arriving after reset are protocol errors and are ignored, per the rule above.

Test Plan:
- Reset release, ready = 1, 1-cycle memory returning addr as data, decode ready = 1 → requests at 0x0, 0x4, 0x8…; instr_out/pc_out pairs (0x0, 0x0), (0x4, 0x4)… one per cycle, no gaps after fill.
- Decode ready = 0, memory answers every request → exactly DEPTH = 4 requests accepted, mem_req_valid_out = 0 afterwards, instr_out holds 0x0. Raise ready → 4 pops in consecutive cycles, requests resume.
- Memory latency 3, two requests outstanding, redirect to 0x100 → both stale responses dropped; next delivered pair is (data@0x100, pc 0x100); count = 0 in the cycle after redirect.
- Redirect coincident with a response, decode valid and ready → that response is dropped, no pop is counted, drop = outstanding − 1, and the next delivered PC is the target.
- redirect_pc_in = 0x203 → mem_req_addr_out = 0x200, pc_out = 0x200.
- Assert rst_n_in mid-stream with FIFO at 3 entries → outputs return to reset values asynchronously; after release, fetch restarts at RESET_PC, and a spurious response with outstanding = 0 leaves count = 0.
